// File: rtl/jtag_tap_controller_if.sv
// Pin-side and data_registers-side signals of the JTAG TAP controller.
// The slave modport is the TAP controller; the master modport is whatever drives the pins.
interface jtag_tap_controller_if;
    logic       tck_pin;
    logic       tms_pin;
    logic       tdi_pin;
    logic       reg_tdo_from_dr;
    logic       reg_tck_enable;
    logic       reg_digital_input;
    logic       reg_test_logic_reset;
    logic       reg_capture_dr;
    logic       reg_shift_dr;
    logic       reg_update_dr;
    logic       reg_capture_ir;
    logic       reg_shift_ir;
    logic       reg_update_ir;
    logic       tdo_pin;
    logic       tdo_oe;
    logic [3:0] reg_tap_state;

    modport master (
        output tck_pin, tms_pin, tdi_pin, reg_tdo_from_dr,
        input  reg_tck_enable, reg_digital_input, reg_test_logic_reset,
               reg_capture_dr, reg_shift_dr, reg_update_dr,
               reg_capture_ir, reg_shift_ir, reg_update_ir,
               tdo_pin, tdo_oe, reg_tap_state
    );

    modport slave (
        input  tck_pin, tms_pin, tdi_pin, reg_tdo_from_dr,
        output reg_tck_enable, reg_digital_input, reg_test_logic_reset,
               reg_capture_dr, reg_shift_dr, reg_update_dr,
               reg_capture_ir, reg_shift_ir, reg_update_ir,
               tdo_pin, tdo_oe, reg_tap_state
    );
endinterface

// File: rtl/jtag_tap_controller.sv
// JTAG pin synchronizers, TCK edge detect and IEEE 1149.1 TAP state machine in the internal_clk domain.
// Optional TCK glitch filter with matching TMS/TDI delay line: define TCK_FILTER_EN.
module jtag_tap_controller #(
    parameter int SYNC_STAGES = 2,
    parameter int FILTER_LEN  = 3
) (
    input logic                  internal_clk,
    input logic                  reg_trst,
    jtag_tap_controller_if.slave bus
);
    localparam logic [3:0] TLR   = 4'hF;
    localparam logic [3:0] RTI   = 4'hC;
    localparam logic [3:0] SELDR = 4'h7;
    localparam logic [3:0] CAPDR = 4'h6;
    localparam logic [3:0] SHDR  = 4'h2;
    localparam logic [3:0] EX1DR = 4'h1;
    localparam logic [3:0] PSDR  = 4'h3;
    localparam logic [3:0] EX2DR = 4'h0;
    localparam logic [3:0] UPDR  = 4'h5;
    localparam logic [3:0] SELIR = 4'h4;
    localparam logic [3:0] CAPIR = 4'hE;
    localparam logic [3:0] SHIR  = 4'hA;
    localparam logic [3:0] EX1IR = 4'h9;
    localparam logic [3:0] PSIR  = 4'hB;
    localparam logic [3:0] EX2IR = 4'h8;
    localparam logic [3:0] UPIR  = 4'hD;

    if (SYNC_STAGES < 2 || FILTER_LEN < 1) begin : g_param_guard
        $error("jtag_tap_controller: SYNC_STAGES must be >= 2 and FILTER_LEN >= 1");
    end

    logic [SYNC_STAGES-1:0] tck_sync_q, tms_sync_q, tdi_sync_q;
    logic                   tck_s, tms_s, tdi_s;
    logic                   tck_f, tms_f, tdi_f;
    logic                   tck_d_q, tck_en_q, tms_a_q, tdi_a_q;
    logic                   rise, fall;
    logic [3:0]             state_q, state_d;
    logic                   tdo_q, tdo_oe_q;

    // NOTE: synchronizer flops take a reset too, so a TCK edge in flight when reset hits is discarded.
    always_ff @(posedge internal_clk) begin
        if (reg_trst) begin
            tck_sync_q <= '0;
            tms_sync_q <= '1;
            tdi_sync_q <= '0;
        end else begin
            tck_sync_q[0] <= bus.tck_pin;
            tms_sync_q[0] <= bus.tms_pin;
            tdi_sync_q[0] <= bus.tdi_pin;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                tck_sync_q[i] <= tck_sync_q[i-1];
                tms_sync_q[i] <= tms_sync_q[i-1];
                tdi_sync_q[i] <= tdi_sync_q[i-1];
            end
        end
    end

    assign tck_s = tck_sync_q[SYNC_STAGES-1];
    assign tms_s = tms_sync_q[SYNC_STAGES-1];
    assign tdi_s = tdi_sync_q[SYNC_STAGES-1];

`ifdef TCK_FILTER_EN
    localparam int              CNT_W    = $clog2(FILTER_LEN + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILTER_LEN - 1);

    logic                  tck_filt_q;
    logic [CNT_W-1:0]      filt_cnt_q;
    logic [FILTER_LEN-1:0] tms_dl_q, tdi_dl_q;

    // TMS/TDI delay line keeps them aligned with the filtered TCK.
    always_ff @(posedge internal_clk) begin
        if (reg_trst) begin
            tck_filt_q <= 1'b0;
            filt_cnt_q <= '0;
            tms_dl_q   <= '1;
            tdi_dl_q   <= '0;
        end else begin
            tms_dl_q[0] <= tms_s;
            tdi_dl_q[0] <= tdi_s;
            for (int i = 1; i < FILTER_LEN; i++) begin
                tms_dl_q[i] <= tms_dl_q[i-1];
                tdi_dl_q[i] <= tdi_dl_q[i-1];
            end
            if (tck_s != tck_filt_q) begin
                if (filt_cnt_q == CNT_LAST) begin
                    tck_filt_q <= tck_s;
                    filt_cnt_q <= '0;
                end else begin
                    filt_cnt_q <= filt_cnt_q + 1'b1;
                end
            end else begin
                filt_cnt_q <= '0;
            end
        end
    end

    assign tck_f = tck_filt_q;
    assign tms_f = tms_dl_q[FILTER_LEN-1];
    assign tdi_f = tdi_dl_q[FILTER_LEN-1];
`else
    assign tck_f = tck_s;
    assign tms_f = tms_s;
    assign tdi_f = tdi_s;
`endif

    assign rise = tck_f & ~tck_d_q;
    assign fall = ~tck_f & tck_d_q;

    // NOTE: state_d defaults to the current state before the case, so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        case (state_q)
            TLR:     state_d = tms_a_q ? TLR   : RTI;
            RTI:     state_d = tms_a_q ? SELDR : RTI;
            SELDR:   state_d = tms_a_q ? SELIR : CAPDR;
            CAPDR:   state_d = tms_a_q ? EX1DR : SHDR;
            SHDR:    state_d = tms_a_q ? EX1DR : SHDR;
            EX1DR:   state_d = tms_a_q ? UPDR  : PSDR;
            PSDR:    state_d = tms_a_q ? EX2DR : PSDR;
            EX2DR:   state_d = tms_a_q ? UPDR  : SHDR;
            UPDR:    state_d = tms_a_q ? SELDR : RTI;
            SELIR:   state_d = tms_a_q ? TLR   : CAPIR;
            CAPIR:   state_d = tms_a_q ? EX1IR : SHIR;
            SHIR:    state_d = tms_a_q ? EX1IR : SHIR;
            EX1IR:   state_d = tms_a_q ? UPIR  : PSIR;
            PSIR:    state_d = tms_a_q ? EX2IR : PSIR;
            EX2IR:   state_d = tms_a_q ? UPIR  : SHIR;
            UPIR:    state_d = tms_a_q ? SELDR : RTI;
            default: state_d = TLR;
        endcase
    end

    // The TMS/TDI registers give the one-cycle alignment with the registered rise pulse.
    always_ff @(posedge internal_clk) begin
        if (reg_trst) begin
            tck_d_q  <= 1'b0;
            tck_en_q <= 1'b0;
            tms_a_q  <= 1'b1;
            tdi_a_q  <= 1'b0;
            state_q  <= TLR;
            tdo_q    <= 1'b0;
            tdo_oe_q <= 1'b0;
        end else begin
            tck_d_q  <= tck_f;
            tck_en_q <= rise;
            tms_a_q  <= tms_f;
            tdi_a_q  <= tdi_f;
            if (tck_en_q) begin
                state_q <= state_d;
            end
            if (fall) begin
                if (state_q == SHDR || state_q == SHIR) begin
                    tdo_q    <= bus.reg_tdo_from_dr;
                    tdo_oe_q <= 1'b1;
                end else begin
                    tdo_q    <= 1'b0;
                    tdo_oe_q <= 1'b0;
                end
            end
        end
    end

    assign bus.reg_tck_enable       = tck_en_q;
    assign bus.reg_digital_input    = tdi_a_q;
    assign bus.reg_test_logic_reset = (state_q == TLR);
    assign bus.reg_capture_dr       = (state_q == CAPDR);
    assign bus.reg_shift_dr         = (state_q == SHDR);
    assign bus.reg_update_dr        = (state_q == UPDR);
    assign bus.reg_capture_ir       = (state_q == CAPIR);
    assign bus.reg_shift_ir         = (state_q == SHIR);
    assign bus.reg_update_ir        = (state_q == UPIR);
    assign bus.tdo_pin              = tdo_q;
    assign bus.tdo_oe               = tdo_oe_q;
    assign bus.reg_tap_state        = state_q;
endmodule

// File: tb/tb_jtag_tap_controller.sv
// Directed bench for jtag_tap_controller: reset, DR/IR walks, TDO timing, TLR recovery and TCK glitches.
// Expectations follow TCK_FILTER_EN when the bench is compiled with that macro.
module tb_jtag_tap_controller;
    localparam int SYNC_STAGES = 2;
    localparam int FILTER_LEN  = 3;
    localparam int HALF        = 8;
`ifdef TCK_FILTER_EN
    localparam int LAT         = SYNC_STAGES + FILTER_LEN + 1;
    localparam int GLITCH_EXP  = 0;
`else
    localparam int LAT         = SYNC_STAGES + 1;
    localparam int GLITCH_EXP  = 1;
`endif

    logic internal_clk = 1'b0;
    logic reg_trst     = 1'b1;
    int   n_checks     = 0;
    int   n_fail       = 0;
    int   pulse_cnt    = 0;
    int   upd_ir_cnt   = 0;
    logic last_tdi     = 1'b0;

    jtag_tap_controller_if tap_if ();

    jtag_tap_controller #(
        .SYNC_STAGES(SYNC_STAGES),
        .FILTER_LEN (FILTER_LEN)
    ) dut (
        .internal_clk(internal_clk),
        .reg_trst    (reg_trst),
        .bus         (tap_if.slave)
    );

    always #5 internal_clk = ~internal_clk;

    always @(negedge internal_clk) begin
        if (tap_if.reg_tck_enable === 1'b1) begin
            pulse_cnt++;
            last_tdi = tap_if.reg_digital_input;
        end
        if (tap_if.reg_update_ir === 1'b1) upd_ir_cnt++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [5:0] decodes();
        return {tap_if.reg_capture_dr, tap_if.reg_shift_dr, tap_if.reg_update_dr,
                tap_if.reg_capture_ir, tap_if.reg_shift_ir, tap_if.reg_update_ir};
    endfunction

    task automatic tck_cycle(input logic tms, input logic tdi);
        tap_if.tms_pin = tms;
        tap_if.tdi_pin = tdi;
        tap_if.tck_pin = 1'b1;
        repeat (HALF) @(negedge internal_clk);
        tap_if.tck_pin = 1'b0;
        repeat (HALF) @(negedge internal_clk);
    endtask

    task automatic test_reset();
        tap_if.tck_pin = 1'b0; tap_if.tms_pin = 1'b1; tap_if.tdi_pin = 1'b0;
        tap_if.reg_tdo_from_dr = 1'b0;
        reg_trst = 1'b1;
        repeat (3) @(negedge internal_clk);
        n_checks++; if (tap_if.reg_tap_state !== 4'hF) begin n_fail++;
            $display("FAIL reset_state: got %h want F", tap_if.reg_tap_state); end
        n_checks++; if (tap_if.reg_test_logic_reset !== 1'b1) begin n_fail++;
            $display("FAIL reset_tlr: got %b want 1", tap_if.reg_test_logic_reset); end
        n_checks++; if (decodes() !== 6'b0) begin n_fail++;
            $display("FAIL reset_decodes: got %b want 000000", decodes()); end
        n_checks++; if (tap_if.reg_tck_enable !== 1'b0) begin n_fail++;
            $display("FAIL reset_tck_en: got %b want 0", tap_if.reg_tck_enable); end
        n_checks++; if ({tap_if.tdo_pin, tap_if.tdo_oe} !== 2'b00) begin n_fail++;
            $display("FAIL reset_tdo: got %b want 00", {tap_if.tdo_pin, tap_if.tdo_oe}); end
        reg_trst = 1'b0;
        repeat (HALF) @(negedge internal_clk);
    endtask

    task automatic test_dr_path();
        logic [3:0] exp_st [3] = '{4'h7, 4'h6, 4'h2};
        logic       tms_v  [3] = '{1'b1, 1'b0, 1'b0};
        int lat = 0;
        pulse_cnt = 0;
        tap_if.tms_pin = 1'b0;
        tap_if.tck_pin = 1'b1;
        for (int k = 1; k <= 20 && lat == 0; k++) begin
            @(negedge internal_clk);
            if (tap_if.reg_tck_enable === 1'b1) lat = k;
        end
        n_checks++; if (lat != LAT) begin n_fail++;
            $display("FAIL dr_latency: got %0d cycles want %0d", lat, LAT); end
        if (lat != 0) repeat (HALF - lat) @(negedge internal_clk);
        tap_if.tck_pin = 1'b0;
        repeat (HALF) @(negedge internal_clk);
        n_checks++; if (tap_if.reg_tap_state !== 4'hC) begin n_fail++;
            $display("FAIL dr_state0: got %h want C", tap_if.reg_tap_state); end
        for (int i = 0; i < 3; i++) begin
            tck_cycle(tms_v[i], 1'b0);
            n_checks++; if (tap_if.reg_tap_state !== exp_st[i]) begin n_fail++;
                $display("FAIL dr_state%0d: got %h want %h", i + 1, tap_if.reg_tap_state, exp_st[i]); end
        end
        n_checks++; if (tap_if.reg_shift_dr !== 1'b1) begin n_fail++;
            $display("FAIL dr_shift_dr: got %b want 1", tap_if.reg_shift_dr); end
        n_checks++; if (pulse_cnt != 4) begin n_fail++;
            $display("FAIL dr_pulses: got %0d want 4", pulse_cnt); end
        n_checks++; if ({tap_if.tdo_pin, tap_if.tdo_oe} !== 2'b01) begin n_fail++;
            $display("FAIL dr_tdo_shift0: got %b want 01", {tap_if.tdo_pin, tap_if.tdo_oe}); end
    endtask

    task automatic test_tdo();
        tap_if.reg_tdo_from_dr = 1'b1;
        tap_if.tms_pin = 1'b0;
        tap_if.tck_pin = 1'b1;
        repeat (HALF) @(negedge internal_clk);
        tap_if.tck_pin = 1'b0;
        for (int k = 1; k <= HALF; k++) begin
            @(negedge internal_clk);
            if (k == LAT - 1) begin
                n_checks++; if (tap_if.tdo_pin !== 1'b0) begin n_fail++;
                    $display("FAIL tdo_before_fall: got %b want 0", tap_if.tdo_pin); end
            end
            if (k == LAT) begin
                n_checks++; if ({tap_if.tdo_pin, tap_if.tdo_oe} !== 2'b11) begin n_fail++;
                    $display("FAIL tdo_after_fall: got %b want 11", {tap_if.tdo_pin, tap_if.tdo_oe}); end
            end
        end
        n_checks++; if (tap_if.reg_tap_state !== 4'h2) begin n_fail++;
            $display("FAIL tdo_stay_shdr: got %h want 2", tap_if.reg_tap_state); end
        tck_cycle(1'b1, 1'b0);
        n_checks++; if (tap_if.reg_tap_state !== 4'h1) begin n_fail++;
            $display("FAIL tdo_ex1dr: got %h want 1", tap_if.reg_tap_state); end
        n_checks++; if ({tap_if.tdo_pin, tap_if.tdo_oe} !== 2'b00) begin n_fail++;
            $display("FAIL tdo_off: got %b want 00", {tap_if.tdo_pin, tap_if.tdo_oe}); end
    endtask

    task automatic test_reset_mid_scan();
        logic [3:0] exp_st [3] = '{4'h3, 4'h0, 4'h2};
        logic       tms_v  [3] = '{1'b0, 1'b1, 1'b0};
        for (int i = 0; i < 3; i++) begin
            tck_cycle(tms_v[i], 1'b0);
            n_checks++; if (tap_if.reg_tap_state !== exp_st[i]) begin n_fail++;
                $display("FAIL rst_walk%0d: got %h want %h", i, tap_if.reg_tap_state, exp_st[i]); end
        end
        n_checks++; if ({tap_if.tdo_pin, tap_if.tdo_oe} !== 2'b11) begin n_fail++;
            $display("FAIL rst_pre_tdo: got %b want 11", {tap_if.tdo_pin, tap_if.tdo_oe}); end
        reg_trst = 1'b1;
        @(negedge internal_clk);
        reg_trst = 1'b0;
        n_checks++; if (tap_if.reg_tap_state !== 4'hF) begin n_fail++;
            $display("FAIL rst_mid_state: got %h want F", tap_if.reg_tap_state); end
        n_checks++; if (tap_if.reg_test_logic_reset !== 1'b1 || tap_if.reg_shift_dr !== 1'b0) begin n_fail++;
            $display("FAIL rst_mid_decode: got tlr=%b shdr=%b want 1/0",
                     tap_if.reg_test_logic_reset, tap_if.reg_shift_dr); end
        n_checks++; if ({tap_if.tdo_pin, tap_if.tdo_oe} !== 2'b00) begin n_fail++;
            $display("FAIL rst_mid_tdo: got %b want 00", {tap_if.tdo_pin, tap_if.tdo_oe}); end
        tap_if.reg_tdo_from_dr = 1'b0;
        repeat (HALF) @(negedge internal_clk);
    endtask

    task automatic test_ir_path();
        logic [3:0] walk_st [5] = '{4'hC, 4'h7, 4'h4, 4'hE, 4'hA};
        logic       walk_tms[5] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        logic [3:0] sh_st   [4] = '{4'hA, 4'hA, 4'hA, 4'h9};
        logic       sh_tms  [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
        logic       sh_tdi  [4] = '{1'b1, 1'b0, 1'b0, 1'b0};
        for (int i = 0; i < 5; i++) begin
            tck_cycle(walk_tms[i], 1'b0);
            n_checks++; if (tap_if.reg_tap_state !== walk_st[i]) begin n_fail++;
                $display("FAIL ir_walk%0d: got %h want %h", i, tap_if.reg_tap_state, walk_st[i]); end
        end
        n_checks++; if (tap_if.reg_shift_ir !== 1'b1) begin n_fail++;
            $display("FAIL ir_shift_ir: got %b want 1", tap_if.reg_shift_ir); end
        for (int i = 0; i < 4; i++) begin
            tck_cycle(sh_tms[i], sh_tdi[i]);
            n_checks++; if (tap_if.reg_tap_state !== sh_st[i]) begin n_fail++;
                $display("FAIL ir_shift_state%0d: got %h want %h", i, tap_if.reg_tap_state, sh_st[i]); end
            n_checks++; if (last_tdi !== sh_tdi[i]) begin n_fail++;
                $display("FAIL ir_tdi%0d: got %b want %b", i, last_tdi, sh_tdi[i]); end
        end
        upd_ir_cnt = 0;
        tck_cycle(1'b1, 1'b0);
        n_checks++; if (tap_if.reg_tap_state !== 4'hD || tap_if.reg_update_ir !== 1'b1) begin n_fail++;
            $display("FAIL ir_upir: got state %h upd %b want D/1", tap_if.reg_tap_state, tap_if.reg_update_ir); end
        tck_cycle(1'b0, 1'b0);
        n_checks++; if (upd_ir_cnt != 2 * HALF) begin n_fail++;
            $display("FAIL ir_update_width: got %0d cycles want %0d", upd_ir_cnt, 2 * HALF); end
        n_checks++; if (tap_if.reg_tap_state !== 4'hC) begin n_fail++;
            $display("FAIL ir_back_rti: got %h want C", tap_if.reg_tap_state); end
    endtask

    task automatic test_tlr_from_psir();
        logic [3:0] exp_st [11] = '{4'h7, 4'h4, 4'hE, 4'hA, 4'h9, 4'hB,
                                    4'h8, 4'hD, 4'h7, 4'h4, 4'hF};
        logic       tms_v  [11] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0,
                                    1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
        for (int i = 0; i < 11; i++) begin
            tck_cycle(tms_v[i], 1'b0);
            n_checks++; if (tap_if.reg_tap_state !== exp_st[i]) begin n_fail++;
                $display("FAIL tlr_walk%0d: got %h want %h", i, tap_if.reg_tap_state, exp_st[i]); end
        end
        n_checks++; if (tap_if.reg_test_logic_reset !== 1'b1) begin n_fail++;
            $display("FAIL tlr_level: got %b want 1", tap_if.reg_test_logic_reset); end
    endtask

    task automatic test_glitch();
        tap_if.tms_pin = 1'b1;
        pulse_cnt = 0;
        tap_if.tck_pin = 1'b1;
        repeat (2) @(negedge internal_clk);
        tap_if.tck_pin = 1'b0;
        repeat (20) @(negedge internal_clk);
        n_checks++; if (pulse_cnt != GLITCH_EXP) begin n_fail++;
            $display("FAIL glitch_2cyc: got %0d pulses want %0d", pulse_cnt, GLITCH_EXP); end
        pulse_cnt = 0;
        tap_if.tck_pin = 1'b1;
        repeat (6) @(negedge internal_clk);
        tap_if.tck_pin = 1'b0;
        repeat (20) @(negedge internal_clk);
        n_checks++; if (pulse_cnt != 1) begin n_fail++;
            $display("FAIL glitch_6cyc: got %0d pulses want 1", pulse_cnt); end
        n_checks++; if (tap_if.reg_tap_state !== 4'hF) begin n_fail++;
            $display("FAIL glitch_state: got %h want F", tap_if.reg_tap_state); end
    endtask

    initial begin
        test_reset();
        test_dr_path();
        test_tdo();
        test_reset_mid_scan();
        test_ir_path();
        test_tlr_from_psir();
        test_glitch();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
